// File: rtl/div_pkg.sv
// div_pkg: shared types and defaults for the divider issuer.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT   = 10;
  localparam int unsigned DIV_TIMEOUT_DEFAULT = 63;

  // Response status reported alongside rsp_q
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_DVZ     = 2'b01,
    ST_OVF     = 2'b10,
    ST_TIMEOUT = 2'b11
  } div_status_e;

  // Issuer control states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } div_state_e;

  // Error status when the divider drops busy without a valid result.
  // Divide-by-zero dominates; any other failure is reported as overflow.
  function automatic div_status_e err_status(input logic dvz, input logic ovf);
    div_status_e st;
    if (dvz) begin
      st = ST_DVZ;
    end else if (ovf) begin
      st = ST_OVF;
    end else begin
      st = ST_OVF;
    end
    return st;
  endfunction

endpackage

// File: rtl/div_issuer_if.sv
// div_issuer_if: command, divider and response signals of the issuer.
// slave  = the issuer itself, master = the surrounding environment.
interface div_issuer_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_dividend;
  logic [WIDTH-1:0] cmd_divisor;

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_busy;
  logic             div_valid;
  logic             div_dvz;
  logic             div_ovf;
  logic [WIDTH-1:0] div_q;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_q;
  div_status_e      rsp_status;

  modport slave (
    input  cmd_valid, cmd_dividend, cmd_divisor,
    input  div_busy, div_valid, div_dvz, div_ovf, div_q,
    input  rsp_ready,
    output cmd_ready, div_start, div_a, div_b,
    output rsp_valid, rsp_q, rsp_status
  );

  modport master (
    output cmd_valid, cmd_dividend, cmd_divisor,
    output div_busy, div_valid, div_dvz, div_ovf, div_q,
    output rsp_ready,
    input  cmd_ready, div_start, div_a, div_b,
    input  rsp_valid, rsp_q, rsp_status
  );

endinterface

// File: rtl/div_timer.sv
// div_timer: counts consecutive wait cycles; expired flags the TIMEOUT-th one.
// Only built when DIV_ISSUER_TIMEOUT_EN is defined. TIMEOUT must be >= 1.
module div_timer
  import div_pkg::*;
#(
  parameter int unsigned TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Combinational flag: this enabled cycle is the last one allowed
  assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));

  // Next count: clear on issue, advance while waiting, stop at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_issuer.sv
// div_issuer: accepts a divide command, drives the divider handshake and
// returns quotient plus status. Define DIV_ISSUER_TIMEOUT_EN to bound the
// wait for the divider by TIMEOUT cycles (status ST_TIMEOUT on expiry).
module div_issuer
  import div_pkg::*;
#(
  parameter int unsigned WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  div_issuer_if.slave bus
);

  div_state_e       state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             div_start_q, div_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;
  div_status_e      rsp_status_q, rsp_status_d;
  logic             expired_c;

`ifdef DIV_ISSUER_TIMEOUT_EN
  logic tmr_clr_c;
  logic tmr_en_c;

  assign tmr_clr_c = (state_q == ISSUE);
  assign tmr_en_c  = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

  div_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr_c),
    .en      (tmr_en_c),
    .expired (expired_c)
  );
`else
  // No timer: never expires, TIMEOUT has no effect
  assign expired_c = 1'b0 & (TIMEOUT == 0);
`endif

  // Next state, latched operands/response, and registered outputs derived from next state
  always_comb begin
    state_d      = state_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    rsp_q_d      = rsp_q_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = ISSUE;
          div_a_d = bus.cmd_dividend;
          div_b_d = bus.cmd_divisor;
        end
      end

      ISSUE: begin
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (expired_c) begin
          state_d      = RESP;
          rsp_q_d      = '0;
          rsp_status_d = ST_TIMEOUT;
        end else if (bus.div_busy) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // A valid result beats a simultaneous busy fall, which beats the timeout
        if (bus.div_valid) begin
          state_d      = RESP;
          rsp_q_d      = bus.div_q;
          rsp_status_d = ST_OK;
        end else if (!bus.div_busy) begin
          state_d      = RESP;
          rsp_q_d      = '0;
          rsp_status_d = err_status(bus.div_dvz, bus.div_ovf);
        end else if (expired_c) begin
          state_d      = RESP;
          rsp_q_d      = '0;
          rsp_status_d = ST_TIMEOUT;
        end
      end

      RESP: begin
        if (bus.rsp_ready && rsp_valid_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    div_start_d = (state_d == ISSUE) || (state_d == WAIT_BUSY);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      div_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      rsp_q_q      <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      div_start_q  <= div_start_d;
      rsp_valid_q  <= rsp_valid_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      rsp_q_q      <= rsp_q_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.div_start  = div_start_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_q      = rsp_q_q;
  assign bus.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_div_issuer.sv
// tb_div_issuer: scoreboard bench for div_issuer with an emulated divider.
module tb_div_issuer;
  import div_pkg::*;

  localparam int unsigned W  = 10;
  localparam int unsigned TO = 8;

  localparam int M_OK      = 0;  // valid, busy held through the valid cycle
  localparam int M_OK_DROP = 1;  // valid and busy fall together
  localparam int M_DVZ     = 2;
  localparam int M_OVF     = 3;
  localparam int M_NONE    = 4;  // busy falls with no flags
  localparam int M_BOTH    = 5;  // dvz and ovf together

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   st;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  div_issuer_if #(.WIDTH(W)) bus ();

  div_issuer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the issuer must report for a given divider behaviour
  function automatic exp_t model(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.q = '0;
    case (mode)
      M_OK, M_OK_DROP: begin
        e.q  = a / b;
        e.st = 2'b00;
      end
      M_DVZ, M_BOTH: e.st = 2'b01;
      default:       e.st = 2'b10;
    endcase
    return e;
  endfunction

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_cmd_ready"},  32'(bus.cmd_ready),  0);
    chk({tag, "_div_start"},  32'(bus.div_start),  0);
    chk({tag, "_div_a"},      32'(bus.div_a),      0);
    chk({tag, "_div_b"},      32'(bus.div_b),      0);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid),  0);
    chk({tag, "_rsp_q"},      32'(bus.rsp_q),      0);
    chk({tag, "_rsp_status"}, 32'(bus.rsp_status), 0);
  endtask

  // Wait for cmd_ready, present one command, and check it was latched
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_dividend = a;
    bus.cmd_divisor  = b;
    tick();
    bus.cmd_valid    = 1'b0;
    bus.cmd_dividend = W'($urandom);
    bus.cmd_divisor  = W'($urandom);
    chk("div_a", 32'(bus.div_a), 32'(a));
    chk("div_b", 32'(bus.div_b), 32'(b));
    chk("start_issue", 32'(bus.div_start), 1);
    chk("ready_low", 32'(bus.cmd_ready), 0);
  endtask

  // One full transaction with the emulated divider
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                         input int bdly, input int ddly, input int stall, input int stray);
    exp_t e;
    e = model(mode, a, b);
    accept(a, b);
    exp_q.push_back(e);
    for (int i = 0; i <= bdly; i++) begin
      tick();
      chk("start_wait_busy", 32'(bus.div_start), 1);
    end
    bus.div_busy = 1'b1;
    for (int i = 0; i <= ddly; i++) begin
      tick();
      chk("start_low", 32'(bus.div_start), 0);
      chk("rsp_early", 32'(bus.rsp_valid), 0);
    end
    case (mode)
      M_OK: begin
        bus.div_valid = 1'b1;
        bus.div_q     = a / b;
      end
      M_OK_DROP: begin
        bus.div_valid = 1'b1;
        bus.div_q     = a / b;
        bus.div_busy  = 1'b0;
      end
      M_DVZ: begin
        bus.div_busy = 1'b0;
        bus.div_dvz  = 1'b1;
      end
      M_OVF: begin
        bus.div_busy = 1'b0;
        bus.div_ovf  = 1'b1;
      end
      M_BOTH: begin
        bus.div_busy = 1'b0;
        bus.div_dvz  = 1'b1;
        bus.div_ovf  = 1'b1;
      end
      default: bus.div_busy = 1'b0;
    endcase
    tick();
    bus.div_valid = 1'b0;
    bus.div_busy  = 1'b0;
    bus.div_dvz   = 1'b0;
    bus.div_ovf   = 1'b0;
    bus.div_q     = W'($urandom);
    chk("rsp_valid_on_time", 32'(bus.rsp_valid), 1);
    if (stray != 0) begin
      bus.div_valid = 1'b1;
      bus.div_q     = W'($urandom);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("hold_valid",  32'(bus.rsp_valid),  1);
      chk("hold_q",      32'(bus.rsp_q),      32'(e.q));
      chk("hold_status", 32'(bus.rsp_status), 32'(e.st));
      chk("hold_ready",  32'(bus.cmd_ready),  0);
    end
    bus.div_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_done", 32'(bus.rsp_valid), 0);
    chk("ready_back", 32'(bus.cmd_ready), 1);
  endtask

  // Divider that never responds
  task automatic run_nobusy();
    accept(10'd321, 10'd9);
`ifdef DIV_ISSUER_TIMEOUT_EN
    begin
      exp_t e;
      e.q  = '0;
      e.st = 2'b11;
      exp_q.push_back(e);
    end
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk("to_waiting", 32'(bus.rsp_valid), 0);
    end
    tick();
    chk("to_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("to_status", 32'(bus.rsp_status), 3);
    chk("to_q", 32'(bus.rsp_q), 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_ready_back", 32'(bus.cmd_ready), 1);
`else
    repeat (100) tick();
    chk("still_waiting_rsp", 32'(bus.rsp_valid), 0);
    chk("still_waiting_start", 32'(bus.div_start), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("recover_ready", 32'(bus.cmd_ready), 1);
`endif
  endtask

  // Reset in WAIT_DONE abandons the transaction; stray completions in IDLE are ignored
  task automatic run_reset_mid();
    accept(10'd77, 10'd5);
    tick();
    bus.div_busy = 1'b1;
    tick();
    chk("pre_rst_start", 32'(bus.div_start), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_rst_outputs("mid_rst");
    bus.div_busy = 1'b0;
    tick();
    tick();
    chk_rst_outputs("hold_rst");
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);
    bus.div_valid = 1'b1;
    bus.div_busy  = 1'b1;
    bus.div_q     = W'($urandom);
    repeat (3) begin
      tick();
      chk("stray_idle_rsp", 32'(bus.rsp_valid), 0);
      chk("stray_idle_ready", 32'(bus.cmd_ready), 1);
    end
    bus.div_valid = 1'b0;
    bus.div_busy  = 1'b0;
    tick();
  endtask

  // Monitor: compare each transferred response against the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got q=%0h status=%0d with nothing expected", bus.rsp_q, bus.rsp_status);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_q", 32'(bus.rsp_q), 32'(e.q));
          chk("rsp_status", 32'(bus.rsp_status), 32'(e.st));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.cmd_valid    = 1'b0;
    bus.cmd_dividend = '0;
    bus.cmd_divisor  = '0;
    bus.div_busy     = 1'b0;
    bus.div_valid    = 1'b0;
    bus.div_dvz      = 1'b0;
    bus.div_ovf      = 1'b0;
    bus.div_q        = '0;
    bus.rsp_ready    = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    chk_rst_outputs("rst_noclk");
    tick();
    tick();
    chk_rst_outputs("rst_clk");
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(bus.cmd_ready), 1);

    run_txn(10'd100, 10'd7, M_OK, 0, 0, 0, 0);
    run_txn(10'd50, 10'd0, M_DVZ, 0, 1, 0, 0);
    run_txn(10'd300, 10'd3, M_OVF, 1, 0, 5, 0);
    run_txn(10'd999, 10'd31, M_OK_DROP, 2, 3, 1, 1);
    run_txn(10'd12, 10'd4, M_NONE, 0, 2, 2, 0);
    run_txn(10'd0, 10'd0, M_BOTH, 1, 1, 0, 1);
    run_txn(10'd1023, 10'd1, M_OK, 0, 0, 3, 1);

    run_nobusy();
    run_reset_mid();

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           mode;
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b    = '0;
        mode = ($urandom_range(0, 1) == 0) ? M_DVZ : M_BOTH;
      end else begin
        b    = W'($urandom_range(1, 1023));
        mode = int'($urandom_range(0, 5));
      end
      run_txn(a, b, mode, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
